mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-ported, fixed-latency main memory between the fetch stage and the memory stage of the 5-stage pipeline. It issues one access at a time, captures returned data and pulses a per-requester completion strobe. It drives the stall outputs that freeze the pipeline alongside the hazard stall. Fetch and data each hold a level request until served, and the arbiter alternates on conflict so neither starves.

## Interface
- MEM_LAT, 4: cycles from the mem_en cycle to the cycle mem_rdata is valid; must be at least 1.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- d_rd  in  1  data read request; held until d_done.
- d_wr  in  1  data write request; held until d_done.
- d_addr  in  ADDR_W  data address; stable while the request is high.
- d_wdata  in  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after mem_en.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_wr  out  1  write qualifier; valid only with mem_en.
- mem_addr  out  ADDR_W  access address; valid only with mem_en.
- mem_wdata  out  DATA_W  write data; valid only with mem_en.
- if_rdata  out  DATA_W  captured fetch data, held until the next fetch completes.
- if_done  out  1  one-cycle fetch completion pulse.
- d_rdata  out  DATA_W  captured load data, held until the next data read completes.
- d_done  out  1  one-cycle data completion pulse, for reads and writes.
- stall_if  out  1  if_req & ~if_done.
- stall_mem  out  1  (d_rd | d_wr) & ~d_done.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, no request: stay in IDLE with mem_en = 0.
- IDLE with a request:
  - mem_en = 1 in the same cycle (combinational issue).
  - Latch the owner (FETCH or DATA) and whether it is a write.
  - Load the counter with MEM_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, register mem_rdata into the owner's rdata register at that edge (skipped for writes) and go to DONE.
- DONE:
  - Assert the owner's done output for exactly 1 cycle.
  - Update last_owner, then go to IDLE. No issue happens in DONE.
- Conflict rule (both requests pending in IDLE):
  - Grant the requester that is not last_owner.
  - last_owner resets to FETCH, so data wins the first conflict.
- d_rd and d_wr both high: treat as a write; d_rd is ignored.
- Address and data are driven from the requester's inputs in the issue cycle; mem_addr/mem_wdata are don't-care otherwise.
- A request that drops before its done is a protocol violation; the result is undefined, but the FSM must still return to IDLE.
- Reset values: state IDLE, counter 0, last_owner FETCH, if_rdata and d_rdata 0, every done output 0, mem_en 0.
- Stall outputs are combinational from inputs and done pulses, so they are 1 immediately after reset if a request is asserted.
- Reset mid-access: abandon the transaction and suppress its done. mem_rdata arriving later is ignored. Write completion in memory is not guaranteed.

## Timing
- Request first seen in IDLE at cycle 0: mem_en in cycle 0, data captured at the end of cycle MEM_LAT, done in cycle MEM_LAT+1.
- Earliest next issue is cycle MEM_LAT+2. Throughput is one access per MEM_LAT+2 cycles.
- MEM_LAT = 1: WAIT lasts 1 cycle; the counter must not underflow.
- Counter width is clog2(MEM_LAT+1).
- The requester may change its address and request in the cycle after done. The arbiter samples that new request in the following IDLE cycle.
- The pipeline stalls on stall_if | stall_mem | the hazard stall. The arbiter does not depend on the hazard stall.

## Structure
- Shared include mem_arb_defs.vh holds:
  - the state encodings IDLE/WAIT/DONE (2-bit localparams);
  - the owner encodings FETCH=0, DATA=1.
- One sub-module, lat_counter: loadable down-counter with load, load value and an at-one flag, parameterised on MEM_LAT.
- Everything else (FSM, capture registers, issue mux) lives in mem_arbiter.

## Test plan
- Reset, then if_req=1 with if_addr=0x0010 and mem_rdata=0xBEEF returned in cycle 4 → mem_en in cycle 0 with mem_addr=0x0010, if_done in cycle 5, if_rdata=0xBEEF; stall_if high in cycles 0–4 and low in cycle 5.
- if_req and d_rd both high after reset → the data read is issued first and d_done comes in cycle 5. The fetch issues in cycle 6 and if_done comes in cycle 11.
- Both requesters held continuously for 4 transactions → the grant order is DATA, FETCH, DATA, FETCH, with no starvation.
- d_wr=1 with d_addr=0x0200 and d_wdata=0x1234 → mem_en and mem_wr in cycle 0 carrying 0x0200/0x1234, d_done in cycle 5, d_rdata unchanged from its prior value.
- rst asserted in cycle 2 of a fetch → no if_done ever, mem_en stays 0 until a new request, if_rdata reads 0.
- MEM_LAT=1 build running back-to-back fetches → mem_en in cycles 0 and 3, if_done in cycles 2 and 5.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and owner encodings for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// lat_counter: loadable down-counter that saturates at zero, flags when it holds one
// ports: clk, rst, load (take load_val), load_val, at_one (count == 1)
module lat_counter #(
    parameter int MEM_LAT = 4,
    localparam int CW = $clog2(MEM_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          at_one
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign at_one = cnt == CW'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating arbiter between fetch and data ports for a fixed-latency memory
// ports: if_* fetch request/response, d_* data request/response, mem_* memory side,
//        stall_if/stall_mem pipeline freeze while a request is outstanding
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_if,
    output logic              stall_mem
);
    localparam int CW = $clog2(MEM_LAT + 1);
    state_t state, next;
    owner_t owner, last_owner;
    logic   is_wr, d_req, grant_data, at_one;
    lat_counter #(.MEM_LAT(MEM_LAT)) u_cnt (
        .clk(clk), .rst(rst), .load(mem_en), .load_val(CW'(MEM_LAT)), .at_one(at_one)
    );
    always_comb begin
        d_req      = d_rd | d_wr;
        // data wins when fetch is idle or fetch was served last
        grant_data = d_req & (~if_req | last_owner == FETCH);
        mem_en     = ~rst & state == IDLE & (if_req | d_req);
        mem_wr     = mem_en & grant_data & d_wr;
        mem_addr   = grant_data ? d_addr : if_addr;
        mem_wdata  = d_wdata;
        if_done    = state == DONE & owner == FETCH;
        d_done     = state == DONE & owner == DATA;
        stall_if   = if_req & ~if_done;
        stall_mem  = d_req & ~d_done;
        next       = state;
        case (state)
            IDLE:    next = (if_req | d_req) ? WAIT : IDLE;
            WAIT:    next = at_one ? DONE : WAIT;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= FETCH;
            last_owner <= FETCH;
            is_wr      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= next;
            if (mem_en) begin
                owner <= grant_data ? DATA : FETCH;
                is_wr <= grant_data & d_wr;
            end
            // counter at one means mem_rdata is valid in this cycle
            if (state == WAIT && at_one && !is_wr) begin
                if (owner == FETCH) if_rdata <= mem_rdata;
                else d_rdata <= mem_rdata;
            end
            if (state == DONE) last_owner <= owner;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the memory arbiter at latency 4 and latency 1
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic        if_req = 0, d_rd = 0, d_wr = 0, mem_en, mem_wr, if_done, d_done, stall_if, stall_mem;
    logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata, mem_addr, mem_wdata, if_rdata, d_rdata;
    logic        q_req = 0, q_en, q_wr, q_done, q_ddone, q_sif, q_smem;
    logic [15:0] q_addr = 0, q_rdata_in, q_maddr, q_mwdata, q_rdata, q_drdata;
    logic        zero1 = 0;
    logic [15:0] zero16 = 0;
    int checks = 0, failures = 0;
    mem_arbiter #(.MEM_LAT(4)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_rd(d_rd), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_rdata(mem_rdata), .mem_en(mem_en),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .if_rdata(if_rdata),
        .if_done(if_done), .d_rdata(d_rdata), .d_done(d_done), .stall_if(stall_if),
        .stall_mem(stall_mem)
    );
    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .if_req(q_req), .if_addr(q_addr), .d_rd(zero1), .d_wr(zero1),
        .d_addr(zero16), .d_wdata(zero16), .mem_rdata(q_rdata_in), .mem_en(q_en),
        .mem_wr(q_wr), .mem_addr(q_maddr), .mem_wdata(q_mwdata), .if_rdata(q_rdata),
        .if_done(q_done), .d_rdata(q_drdata), .d_done(q_ddone), .stall_if(q_sif),
        .stall_mem(q_smem)
    );
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'hBEFF;
    endfunction
    logic [3:0]       v4 = '0;
    logic [3:0][15:0] a4 = '0;
    logic             v1 = 0;
    logic [15:0]      a1 = 0;
    always @(posedge clk) begin
        v4 <= {v4[2:0], mem_en};
        a4 <= {a4[2:0], mem_addr};
        v1 <= q_en;
        a1 <= q_maddr;
    end
    assign mem_rdata  = v4[3] ? mem_f(a4[3]) : 16'h0BAD;
    assign q_rdata_in = v1 ? mem_f(a1) : 16'h0BAD;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    initial begin
        if_req = 1;
        step;
        step;
        #1;
        chk("rst_stall_if", stall_if, 1);
        chk("rst_mem_en", mem_en, 0);
        if_req = 0;
        #1;
        chk("rst_stall_if0", stall_if, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 0;
        step;
        if_req = 1; if_addr = 16'h0010;
        for (int c = 0; c <= 5; c++) begin
            #1;
            chk("t1_en", mem_en, c == 0);
            if (c == 0) chk("t1_addr", mem_addr, 16'h0010);
            chk("t1_stall", stall_if, c < 5);
            chk("t1_done", if_done, c == 5);
            if (c == 5) begin
                chk("t1_rdata", if_rdata, 16'hBEEF);
                if_req = 0;
            end
            step;
        end
        rst = 1;
        step;
        rst = 0;
        if_req = 1; if_addr = 16'h0020; d_rd = 1; d_addr = 16'h0100;
        for (int c = 0; c <= 11; c++) begin
            #1;
            chk("t2_en", mem_en, c == 0 || c == 6);
            if (c == 0) begin
                chk("t2_addr_d", mem_addr, 16'h0100);
                chk("t2_wr", mem_wr, 0);
            end
            if (c == 6) chk("t2_addr_f", mem_addr, 16'h0020);
            chk("t2_d_done", d_done, c == 5);
            chk("t2_if_done", if_done, c == 11);
            if (c < 5) chk("t2_stall_mem", stall_mem, 1);
            if (c == 5) begin
                chk("t2_d_rdata", d_rdata, 16'hBFFF);
                d_rd = 0;
            end
            if (c == 11) begin
                chk("t2_if_rdata", if_rdata, 16'hBEDF);
                if_req = 0;
            end
            step;
        end
        if_req = 1; if_addr = 16'h0040; d_rd = 1; d_addr = 16'h0300;
        for (int c = 0; c <= 23; c++) begin
            #1;
            chk("t3_en", mem_en, c % 6 == 0);
            if (c % 6 == 0) chk("t3_grant", mem_addr, ((c / 6) % 2 == 0) ? 16'h0300 : 16'h0040);
            chk("t3_d_done", d_done, c % 6 == 5 && (c / 6) % 2 == 0);
            chk("t3_if_done", if_done, c % 6 == 5 && (c / 6) % 2 == 1);
            if (c == 23) begin
                if_req = 0;
                d_rd = 0;
            end
            step;
        end
        #1;
        chk("t3_d_rdata", d_rdata, 16'hBDFF);
        chk("t3_if_rdata", if_rdata, 16'hBEBF);
        d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
        for (int c = 0; c <= 5; c++) begin
            #1;
            chk("t4_en", mem_en, c == 0);
            if (c == 0) begin
                chk("t4_wr", mem_wr, 1);
                chk("t4_addr", mem_addr, 16'h0200);
                chk("t4_wdata", mem_wdata, 16'h1234);
            end
            chk("t4_stall_mem", stall_mem, c < 5);
            chk("t4_done", d_done, c == 5);
            if (c == 5) d_wr = 0;
            step;
        end
        #1;
        chk("t4_d_rdata", d_rdata, 16'hBDFF);
        if_req = 1; if_addr = 16'h0050;
        step;
        step;
        rst = 1; if_req = 0;
        step;
        rst = 0;
        for (int c = 3; c <= 10; c++) begin
            #1;
            chk("t5_en", mem_en, 0);
            chk("t5_done", if_done, 0);
            chk("t5_rdata", if_rdata, 0);
            step;
        end
        q_req = 1; q_addr = 16'h0070;
        for (int c = 0; c <= 5; c++) begin
            #1;
            chk("t6_en", q_en, c == 0 || c == 3);
            chk("t6_done", q_done, c == 2 || c == 5);
            if (c == 3) chk("t6_rdata", q_rdata, 16'hBE8F);
            if (c == 5) q_req = 0;
            step;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
